// File: rtl/dispatch_issue_ctrl.sv
// dispatch_issue_ctrl: serialises privileged issue, parks on IDLE, and inserts a bubble after redirects
module dispatch_issue_ctrl #(
  parameter int PRI_TIMEOUT  = 256,
  parameter int FLUSH_BUBBLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_pri_instr_i,
  input  logic       pri_retire_i,
  input  logic       is_idle_i,
  input  logic       excp_flush_i,
  input  logic       refetch_i,
  input  logic       stallreq_ex_i,
  input  logic       stallreq_mem_i,
  output logic       block_o,
  output logic       stall_o,
  output logic       flush_o,
  output logic [1:0] state_o,
  output logic       timeout_o
);
  localparam int A  = $clog2(PRI_TIMEOUT);
  localparam int B  = $clog2(FLUSH_BUBBLE + 1);
  localparam int AB = A > B ? A : B;
  localparam int CW = AB > 1 ? AB : 1;
  localparam logic [CW-1:0] BUB_LD = FLUSH_BUBBLE > 0 ? CW'(FLUSH_BUBBLE - 1) : '0;
  localparam logic [CW-1:0] TO_MAX = CW'(PRI_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN = 2'b00, PRI_WAIT = 2'b01, CPU_IDLE = 2'b10, DRAIN = 2'b11} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  assign flush_o   = excp_flush_i | refetch_i;
  assign stall_o   = (stallreq_ex_i | stallreq_mem_i) & ~flush_o;
  assign block_o   = state_q != RUN;
  assign state_o   = state_q;
  assign timeout_o = timeout_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (flush_o) begin
      state_d = FLUSH_BUBBLE > 0 ? DRAIN : RUN;
      cnt_d   = BUB_LD;
    end else begin
      case (state_q)
        RUN: if (is_pri_instr_i & ~stall_o) begin
          state_d = PRI_WAIT;
          cnt_d   = '0;
        end
        PRI_WAIT: if (pri_retire_i) begin
          state_d = is_idle_i ? CPU_IDLE : RUN;
        end else if (cnt_q == TO_MAX) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        CPU_IDLE: state_d = CPU_IDLE;
        DRAIN: if (cnt_q == '0) state_d = RUN;
               else cnt_d = cnt_q - CW'(1);
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: doc/dispatch_issue_ctrl.md
Name: dispatch_issue_ctrl

Overview:
Issue-sequencing controller for the dual-issue dispatch stage. It drives dispatch's `block`, `stall` and `flush` inputs.
- Serialises privileged instructions: after a privileged issue, dispatch is blocked until that instruction retires, a flush arrives, or a watchdog expires.
- Parks the core after a retired IDLE.
- Inserts a fixed bubble after every redirect so the frontend can resteer.
It sits between dispatch/EXE/MEM/commit and the pipeline ctrl path.

Parameters:
PRI_TIMEOUT, 256, watchdog cycles in PRI_WAIT before forced release; must be >= 2.
FLUSH_BUBBLE, 2, block cycles inserted after a flush; 0 means no bubble.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
is_pri_instr_i  in  1  dispatch issued a privileged instr this cycle (already gated by ~stall & ~flush)
pri_retire_i  in  1  the outstanding privileged instr retired at commit this cycle
is_idle_i  in  1  the retiring privileged instr is IDLE; valid only with pri_retire_i
excp_flush_i  in  1  exception/ERTN/interrupt redirect from commit
refetch_i  in  1  refetch redirect from commit (CSR/TLB/CACOP side effects)
stallreq_ex_i  in  1  EXE stall request
stallreq_mem_i  in  1  MEM stall request
block_o  out  1  to dispatch `block`
stall_o  out  1  to dispatch/IB `stall`
flush_o  out  1  to dispatch/EXE `flush`
state_o  out  2  current FSM state (debug)
timeout_o  out  1  sticky watchdog-expired flag

Behaviour:
- States: RUN=2'b00, PRI_WAIT=2'b01, CPU_IDLE=2'b10, DRAIN=2'b11. `state_o` is the state register.
- Counter `cnt` is max($clog2(PRI_TIMEOUT), $clog2(FLUSH_BUBBLE+1), 1) bits wide, unsigned, and never wraps.
- Reset (async, any time, including mid-operation):
  - state=RUN, cnt=0, timeout_o=0, block_o=0.
  - Combinational outputs still follow their inputs during reset.
- flush_o = excp_flush_i | refetch_i. Combinational, same cycle, no latency.
- stall_o = (stallreq_ex_i | stallreq_mem_i) & ~flush_o. Combinational; flush always masks stall.
- block_o = (state != RUN). Decoded from the state register only, so a block takes effect the cycle after the triggering event.
- Flush priority: in every state, flush_o=1 at a clock edge forces the following, overriding all other transitions in the same cycle:
  - FLUSH_BUBBLE>0: next state=DRAIN, cnt=FLUSH_BUBBLE-1.
  - FLUSH_BUBBLE=0: next state=RUN, cnt=0.
  - A flush already in DRAIN reloads cnt.
- RUN:
  - is_pri_instr_i & ~stall_o: go to PRI_WAIT, cnt=0.
  - pri_retire_i: ignored.
- PRI_WAIT, checked in order:
  - pri_retire_i & is_idle_i: go to CPU_IDLE.
  - pri_retire_i: go to RUN.
  - cnt==PRI_TIMEOUT-1: go to RUN, set timeout_o.
  - otherwise: cnt+=1 every cycle, stalled or not.
  - is_pri_instr_i: ignored, because dispatch is blocked.
- CPU_IDLE: held indefinitely with block_o=1. Exits only via flush; commit raises excp_flush_i on interrupt wake-up.
- DRAIN:
  - cnt==0: go to RUN.
  - otherwise: cnt-=1.
  - DRAIN therefore blocks for exactly FLUSH_BUBBLE cycles after the flush cycle.
- timeout_o: set the cycle after expiry; cleared only by rst.
- Simultaneous pri_retire_i and flush: flush wins, and the retire is discarded.
- Simultaneous is_pri_instr_i and stall_o in RUN: stay in RUN.

Test Plan:
1. Reset then idle inputs:
   - Required: block_o=0, stall_o=0, flush_o=0, state_o=00, timeout_o=0.
   - Assert rst mid-PRI_WAIT: state_o=00 and block_o=0 immediately, without a clock edge.
2. is_pri_instr_i pulse at cycle 10:
   - Required: block_o=1 from cycle 11, state_o=01.
   - pri_retire_i at cycle 15: block_o=0 from cycle 16, state_o=00.
3. Privileged issue, then pri_retire_i=1 & is_idle_i=1:
   - Required: state_o=10 and block_o=1 held for 100 cycles.
   - excp_flush_i pulse: flush_o=1 that cycle, then state_o=11 for 2 cycles, then 00.
4. Privileged issue with no retire, PRI_TIMEOUT=256:
   - Required: block_o=1 for exactly 256 cycles, then state_o=00 and timeout_o=1 sticky.
   - A later retire leaves timeout_o unchanged.
5. stallreq_mem_i=1 together with refetch_i=1:
   - Required: flush_o=1, stall_o=0.
   - Next cycle with refetch_i=0 and stallreq_mem_i=1: stall_o=1, state_o=11.
   - A second refetch_i during DRAIN extends the block to 2 cycles after it.
6. In RUN, is_pri_instr_i=1 with stallreq_ex_i=1:
   - Required: state stays 00.
   - In PRI_WAIT, pri_retire_i and excp_flush_i in the same cycle: next state_o=11, not 00.
